// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage definitions: FSM encodings, the canonical NOP and PC helpers.
package rv_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_ST_RESET = 2'd0,
    FETCH_ST_RUN   = 2'd1,
    FETCH_ST_DROP  = 2'd2
  } fetch_state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv_fetch_if.sv
// Fetch-stage bus bundle: imem request/response, decode-facing output and stall/kill/redirect controls.
interface rv_fetch_if;
  logic        f_stall_i;
  logic        f_kill_i;
  logic        x_bra_i;
  logic [31:0] x_bra_target_i;
  logic [31:0] im_addr_o;
  logic        im_rd_o;
  logic [31:0] im_data_i;
  logic        im_valid_i;
  logic [31:0] f_ir_o;
  logic [31:0] f_pc_o;
  logic        f_valid_o;

  modport master (
    input  f_stall_i, f_kill_i, x_bra_i, x_bra_target_i, im_data_i, im_valid_i,
    output im_addr_o, im_rd_o, f_ir_o, f_pc_o, f_valid_o
  );

  modport slave (
    output f_stall_i, f_kill_i, x_bra_i, x_bra_target_i, im_data_i, im_valid_i,
    input  im_addr_o, im_rd_o, f_ir_o, f_pc_o, f_valid_o
  );
endinterface

// File: rtl/rv_fetch_skid.sv
// One-entry instruction+pc holding buffer; load/unload take effect on the next edge.
// clr has priority over load, load over unload; the owner guarantees no load while full.
module rv_fetch_skid (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load,
  input  logic        unload,
  input  logic        clr,
  input  logic [31:0] in_ir,
  input  logic [31:0] in_pc,
  output logic        full,
  output logic [31:0] out_ir,
  output logic [31:0] out_pc
);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      full   <= 1'b0;
      out_ir <= '0;
      out_pc <= '0;
    end else if (clr) begin
      full <= 1'b0;
    end else if (load) begin
      full   <= 1'b1;
      out_ir <= in_ir;
      out_pc <= in_pc;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/rv_fetch.sv
// uRV fetch stage: one outstanding imem read, 2-cycle im_rd->f_valid latency, 1 insn/cycle.
// Decode stall freezes outputs, a landing response goes to the skid; redirect beats stall.
module rv_fetch
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] g_RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] g_NOP_INSN     = NOP_INSN
) (
  input logic    clk_i,
  input logic    rst_n_i,
  rv_fetch_if.master bus
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         pend_q, pend_d;
  logic         vld_q, vld_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  opc_q, opc_d;

  logic         resp;
  logic         issue;
  logic         skid_load, skid_unload, skid_clr;
  logic         skid_full;
  logic [31:0]  skid_ir, skid_pc;

  // Responses with nothing outstanding (e.g. left over from before reset) are ignored.
  assign resp  = bus.im_valid_i && pend_q;
  assign issue = (state_q == FETCH_ST_RUN) && (!pend_q || resp) && !skid_full &&
                 !bus.f_stall_i && !bus.x_bra_i;

  assign bus.im_rd_o   = issue;
  assign bus.im_addr_o = issue ? pc_q : 32'h0;
  assign bus.f_valid_o = vld_q;
  assign bus.f_pc_o    = opc_q;
  assign bus.f_ir_o    = vld_q ? ir_q : g_NOP_INSN;

  rv_fetch_skid u_skid (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load    (skid_load),
    .unload  (skid_unload),
    .clr     (skid_clr),
    .in_ir   (bus.im_data_i),
    .in_pc   (fetch_pc_q),
    .full    (skid_full),
    .out_ir  (skid_ir),
    .out_pc  (skid_pc)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= FETCH_ST_RESET;
      pc_q       <= g_RESET_VECTOR;
      fetch_pc_q <= '0;
      pend_q     <= 1'b0;
      vld_q      <= 1'b0;
      ir_q       <= g_NOP_INSN;
      opc_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      pend_q     <= pend_d;
      vld_q      <= vld_d;
      ir_q       <= ir_d;
      opc_q      <= opc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_pc_d  = fetch_pc_q;
    pend_d      = pend_q;
    vld_d       = vld_q;
    ir_d        = ir_q;
    opc_d       = opc_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clr    = 1'b0;

    if (issue) begin
      pc_d       = pc_q + 32'd4;
      fetch_pc_d = pc_q;
      pend_d     = 1'b1;
    end else if (resp) begin
      pend_d = 1'b0;
    end

    case (state_q)
      FETCH_ST_RESET: state_d = FETCH_ST_RUN;

      FETCH_ST_RUN, FETCH_ST_DROP: begin
        if (bus.x_bra_i) begin
          pc_d     = word_align(bus.x_bra_target_i);
          vld_d    = 1'b0;
          skid_clr = 1'b1;
          // A read still in flight must be swallowed before the target is fetched.
          if (pend_q && !bus.im_valid_i) begin
            state_d = FETCH_ST_DROP;
          end else begin
            pend_d  = 1'b0;
            state_d = FETCH_ST_RUN;
          end
        end else if (state_q == FETCH_ST_DROP) begin
          vld_d = 1'b0;
          if (resp) state_d = FETCH_ST_RUN;
        end else if (bus.f_kill_i) begin
          vld_d    = 1'b0;
          skid_clr = 1'b1;
        end else if (!bus.f_stall_i) begin
          if (skid_full) begin
            vld_d       = 1'b1;
            ir_d        = skid_ir;
            opc_d       = skid_pc;
            skid_unload = 1'b1;
          end else if (resp) begin
            vld_d = 1'b1;
            ir_d  = bus.im_data_i;
            opc_d = fetch_pc_q;
          end else begin
            vld_d = 1'b0;
          end
        end else if (resp) begin
          skid_load = 1'b1;
        end
      end

      default: state_d = FETCH_ST_RESET;
    endcase
  end

endmodule

// File: tb/tb_rv_fetch.sv
// Randomised + directed bench for rv_fetch: in-order imem model and an expected-PC stream model.
module tb_rv_fetch;

  localparam logic [31:0] RV  = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rv_fetch_if bus();

  rv_fetch #(.g_RESET_VECTOR(RV), .g_NOP_INSN(NOP)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // stimulus knobs
  bit          drv_rst = 1'b0, drv_stall = 1'b0, drv_bra = 1'b0;
  logic [31:0] drv_tgt = '0;
  int          lat = 1;
  bit          rand_lat = 1'b0;

  // inputs applied this cycle and last cycle
  bit a_rst, a_stall, a_bra, p_rst, p_stall, p_kill;

  // samples
  logic        s_rd, s_vld;
  logic [31:0] s_addr, s_pc, s_ir;
  logic        p_vld;
  logic [31:0] p_pc, p_ir;

  // reference model
  resp_t       mq[$];
  resp_t       rtmp;
  int          cyc = 0;
  logic [31:0] exp_pc = RV;
  logic [31:0] s_exp;
  bit          s_acc;
  int          n_acc = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a < 32'h1000) ? a : ((a ^ 32'h5A3C_0000) + 32'h11);
  endfunction

  task automatic cycle();
    int l;
    @(negedge clk);
    p_vld = s_vld; p_pc = s_pc; p_ir = s_ir;
    p_rst = a_rst; p_stall = a_stall; p_kill = a_bra;
    a_rst = drv_rst; a_stall = drv_stall; a_bra = drv_bra;
    rst_n              = drv_rst;
    bus.f_stall_i      = drv_stall;
    bus.f_kill_i       = drv_bra;
    bus.x_bra_i        = drv_bra;
    bus.x_bra_target_i = drv_tgt;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rtmp           = mq.pop_front();
      bus.im_valid_i = 1'b1;
      bus.im_data_i  = rtmp.data;
    end else begin
      bus.im_valid_i = 1'b0;
      bus.im_data_i  = $urandom;
    end
    #1;
    s_rd = bus.im_rd_o; s_addr = bus.im_addr_o;
    s_vld = bus.f_valid_o; s_pc = bus.f_pc_o; s_ir = bus.f_ir_o;
    // decode consumes a valid, unstalled, unkilled instruction
    s_acc = a_rst && (s_vld === 1'b1) && !a_stall && !a_bra;
    s_exp = exp_pc;
    if (s_acc) begin
      exp_pc = exp_pc + 32'd4;
      n_acc++;
    end
    if (!a_rst)     exp_pc = RV;
    else if (a_bra) exp_pc = {drv_tgt[31:2], 2'b00};
    if (s_rd === 1'b1) begin
      l = rand_lat ? int'($urandom_range(1, 3)) : lat;
      mq.push_back('{data: mem_fn(s_addr), due: cyc + l});
    end
    cyc++;
  endtask

  task automatic test_reset();
    drv_rst = 1'b0;
    repeat (3) cycle();
    checks++; if (s_vld !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", s_vld); end
    checks++; if (s_ir !== NOP) begin errors++; $display("FAIL reset_ir: got %h want %h", s_ir, NOP); end
    checks++; if (s_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", s_pc); end
    checks++; if (s_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", s_rd); end
    checks++; if (s_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", s_addr); end
  endtask

  task automatic test_startup();
    bit found = 1'b0;
    lat = 1; drv_rst = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (s_rd === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL startup_timeout: no im_rd within 10 cycles"); end
    checks++; if (s_addr !== RV) begin errors++; $display("FAIL startup_addr0: got %h want %h", s_addr, RV); end
    cycle();
    checks++; if (s_rd !== 1'b1 || s_addr !== RV + 32'd4) begin errors++; $display("FAIL startup_addr1: rd=%b addr=%h want 1/%h", s_rd, s_addr, RV + 32'd4); end
    checks++; if (s_vld !== 1'b0) begin errors++; $display("FAIL startup_early_valid: got %b want 0", s_vld); end
    cycle();
    checks++; if (s_rd !== 1'b1 || s_addr !== RV + 32'd8) begin errors++; $display("FAIL startup_addr2: rd=%b addr=%h want 1/%h", s_rd, s_addr, RV + 32'd8); end
    checks++; if (s_vld !== 1'b1 || s_pc !== RV || s_ir !== RV) begin errors++; $display("FAIL startup_first: vld=%b pc=%h ir=%h want 1/%h/%h", s_vld, s_pc, s_ir, RV, RV); end
  endtask

  task automatic test_stall();
    int base;
    lat = 1; drv_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (p_stall && !p_kill) begin
        checks++; if (s_vld !== p_vld || s_pc !== p_pc || s_ir !== p_ir) begin errors++; $display("FAIL stall_hold: %b/%h/%h want %b/%h/%h", s_vld, s_pc, s_ir, p_vld, p_pc, p_ir); end
      end
    end
    drv_stall = 1'b0; base = n_acc;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (p_stall && !p_kill) begin
        checks++; if (s_vld !== p_vld || s_pc !== p_pc || s_ir !== p_ir) begin errors++; $display("FAIL stall_hold: %b/%h/%h want %b/%h/%h", s_vld, s_pc, s_ir, p_vld, p_pc, p_ir); end
      end
      if (s_acc) begin
        checks++; if (s_pc !== s_exp || s_ir !== mem_fn(s_exp)) begin errors++; $display("FAIL stream: pc=%h ir=%h want %h/%h", s_pc, s_ir, s_exp, mem_fn(s_exp)); end
      end
    end
    checks++; if (n_acc - base < 5) begin errors++; $display("FAIL stall_resume: %0d accepted want >=5", n_acc - base); end
  endtask

  task automatic test_redirect_idle();
    lat = 1;
    repeat (3) cycle();
    drv_bra = 1'b1; drv_tgt = 32'h2000;
    cycle();
    drv_bra = 1'b0;
    cycle();
    checks++; if (s_vld !== 1'b0) begin errors++; $display("FAIL bra_kill: vld=%b want 0", s_vld); end
    checks++; if (s_rd !== 1'b1 || s_addr !== 32'h2000) begin errors++; $display("FAIL bra_issue: rd=%b addr=%h want 1/00002000", s_rd, s_addr); end
    cycle();
    cycle();
    checks++; if (s_vld !== 1'b1 || s_pc !== 32'h2000) begin errors++; $display("FAIL bra_first: vld=%b pc=%h want 1/00002000", s_vld, s_pc); end
    for (int i = 0; i < 4; i++) begin
      if (s_acc) begin
        checks++; if (s_pc !== s_exp || s_ir !== mem_fn(s_exp)) begin errors++; $display("FAIL stream: pc=%h ir=%h want %h/%h", s_pc, s_ir, s_exp, mem_fn(s_exp)); end
      end
      cycle();
    end
  endtask

  task automatic test_drop();
    bit found = 1'b0, first = 1'b0;
    lat = 3;
    for (int i = 0; i < 16 && !found; i++) begin
      cycle();
      if (s_rd === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL drop_timeout: no im_rd within 16 cycles"); end
    drv_bra = 1'b1; drv_tgt = 32'h2000;
    cycle();
    drv_bra = 1'b0;
    checks++; if (s_rd !== 1'b0) begin errors++; $display("FAIL drop_rd_bra: rd=%b want 0", s_rd); end
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++; if (s_rd !== 1'b0) begin errors++; $display("FAIL drop_rd_wait: rd=%b want 0", s_rd); end
    end
    cycle();
    checks++; if (s_rd !== 1'b1 || s_addr !== 32'h2000) begin errors++; $display("FAIL drop_issue: rd=%b addr=%h want 1/00002000", s_rd, s_addr); end
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (s_acc) begin
        checks++; if (s_pc !== s_exp || s_ir !== mem_fn(s_exp)) begin errors++; $display("FAIL stream: pc=%h ir=%h want %h/%h", s_pc, s_ir, s_exp, mem_fn(s_exp)); end
        if (!first) begin
          first = 1'b1;
          checks++; if (s_pc !== 32'h2000) begin errors++; $display("FAIL drop_first: pc=%h want 00002000", s_pc); end
        end
      end
    end
    checks++; if (!first) begin errors++; $display("FAIL drop_no_output: nothing accepted within 12 cycles"); end
  endtask

  task automatic test_stall_redirect();
    bit first = 1'b0;
    lat = 1;
    repeat (3) cycle();
    drv_stall = 1'b1;
    repeat (2) cycle();
    drv_bra = 1'b1; drv_tgt = 32'h3000;
    cycle();
    drv_bra = 1'b0; drv_stall = 1'b0;
    cycle();
    checks++; if (s_vld !== 1'b0) begin errors++; $display("FAIL sbra_kill: vld=%b want 0", s_vld); end
    checks++; if (s_rd !== 1'b1 || s_addr !== 32'h3000) begin errors++; $display("FAIL sbra_issue: rd=%b addr=%h want 1/00003000", s_rd, s_addr); end
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (s_acc) begin
        checks++; if (s_pc !== s_exp || s_ir !== mem_fn(s_exp)) begin errors++; $display("FAIL stream: pc=%h ir=%h want %h/%h", s_pc, s_ir, s_exp, mem_fn(s_exp)); end
        if (!first) begin
          first = 1'b1;
          checks++; if (s_pc !== 32'h3000) begin errors++; $display("FAIL sbra_first: pc=%h want 00003000", s_pc); end
        end
      end
    end
    checks++; if (!first) begin errors++; $display("FAIL sbra_no_output: nothing accepted within 8 cycles"); end
  endtask

  task automatic test_wrap_reset();
    bit          saw = 1'b0, have = 1'b0, found = 1'b0;
    logic [31:0] last = '0;
    lat = 1;
    drv_bra = 1'b1; drv_tgt = 32'hFFFF_FFF8;
    cycle();
    drv_bra = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (s_rd === 1'b1) begin
        if (have && last == 32'hFFFF_FFFC) begin
          saw = 1'b1;
          checks++; if (s_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 00000000", s_addr); end
        end
        last = s_addr; have = 1'b1;
      end
      if (s_acc) begin
        checks++; if (s_pc !== s_exp || s_ir !== mem_fn(s_exp)) begin errors++; $display("FAIL stream: pc=%h ir=%h want %h/%h", s_pc, s_ir, s_exp, mem_fn(s_exp)); end
      end
    end
    checks++; if (!saw) begin errors++; $display("FAIL wrap_seen: no fetch after FFFFFFFC"); end
    drv_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (!p_rst) begin
        checks++; if (s_vld !== 1'b0 || s_rd !== 1'b0) begin errors++; $display("FAIL midreset: vld=%b rd=%b want 0/0", s_vld, s_rd); end
      end
    end
    drv_rst = 1'b1;
    for (int i = 0; i < 16 && !found; i++) begin
      cycle();
      if (s_rd === 1'b1) found = 1'b1;
    end
    checks++; if (!found || s_addr !== RV) begin errors++; $display("FAIL midreset_vector: found=%b addr=%h want 1/%h", found, s_addr, RV); end
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (s_acc) begin
        checks++; if (s_pc !== s_exp || s_ir !== mem_fn(s_exp)) begin errors++; $display("FAIL stream: pc=%h ir=%h want %h/%h", s_pc, s_ir, s_exp, mem_fn(s_exp)); end
      end
    end
  endtask

  task automatic test_random();
    int base = n_acc;
    rand_lat = 1'b1;
    for (int i = 0; i < 600; i++) begin
      drv_stall = ($urandom_range(0, 3) == 0);
      drv_bra   = ($urandom_range(0, 24) == 0);
      drv_tgt   = $urandom;
      cycle();
      if (s_acc) begin
        checks++; if (s_pc !== s_exp || s_ir !== mem_fn(s_exp)) begin errors++; $display("FAIL stream: pc=%h ir=%h want %h/%h", s_pc, s_ir, s_exp, mem_fn(s_exp)); end
      end
      if (p_stall && !p_kill) begin
        checks++; if (s_vld !== p_vld || s_pc !== p_pc || s_ir !== p_ir) begin errors++; $display("FAIL stall_hold: %b/%h/%h want %b/%h/%h", s_vld, s_pc, s_ir, p_vld, p_pc, p_ir); end
      end
      if (s_vld === 1'b0) begin
        checks++; if (s_ir !== NOP) begin errors++; $display("FAIL invalid_nop: ir=%h want %h", s_ir, NOP); end
      end
    end
    drv_stall = 1'b0; drv_bra = 1'b0; rand_lat = 1'b0;
    checks++; if (n_acc - base < 60) begin errors++; $display("FAIL random_progress: %0d accepted want >=60", n_acc - base); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.f_stall_i = 1'b0; bus.f_kill_i = 1'b0; bus.x_bra_i = 1'b0;
    bus.x_bra_target_i = '0; bus.im_valid_i = 1'b0; bus.im_data_i = '0;
    test_reset();
    test_startup();
    test_stall();
    test_redirect_idle();
    test_drop();
    test_stall_redirect();
    test_wrap_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_fetch.md
Name: rv_fetch

Overview:
Instruction fetch stage of the uRV pipeline. Produces the f_ir/f_pc/f_valid stream consumed by the decode stage and obeys decode's stall and kill. Keeps the program counter and issues word reads to instruction memory. Absorbs a response that lands while decode is stalled, and redirects on branches or jumps resolved in execute.

Parameters:
g_RESET_VECTOR, 32'h00000000, first fetch address after reset.
g_NOP_INSN, 32'h00000013, value driven on f_ir_o while reset or invalid (addi x0,x0,0).

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_n_i  in  1  reset, synchronous, active-low
f_stall_i  in  1  decode stall; hold f_ir_o/f_pc_o/f_valid_o stable
f_kill_i  in  1  flush fetch output; always asserted together with x_bra_i
x_bra_i  in  1  redirect request from execute
x_bra_target_i  in  32  redirect target, word aligned
im_addr_o  out  32  instruction memory read address
im_rd_o  out  1  read strobe, one cycle per request
im_data_i  in  32  read data
im_valid_i  in  1  im_data_i valid; responses in order, latency >=1 cycle
f_ir_o  out  32  fetched instruction to decode
f_pc_o  out  32  PC of f_ir_o
f_valid_o  out  1  f_ir_o/f_pc_o valid

Behaviour:
- Reset (rst_n_i=0 at edge): pc=g_RESET_VECTOR; f_valid_o=0; f_ir_o=g_NOP_INSN; f_pc_o=0; im_rd_o=0; im_addr_o=0; pend=0; skid empty; state=ST_RESET. Reset mid-transfer discards any outstanding response; a late im_valid_i after reset is ignored while state=ST_RESET.
- States:
  - ST_RESET: one cycle, then ST_RUN.
  - ST_RUN: normal operation.
  - ST_DROP: one killed response outstanding; discard the next im_valid_i, then go to ST_RUN.
- Request issue (ST_RUN): im_rd_o=1, im_addr_o=pc when (!pend || im_valid_i) && skid empty && !f_stall_i && !x_bra_i.
  - On issue, pc <= pc+4 (mod 2^32, wrap 32'hFFFFFFFC -> 0) and pend <= 1.
  - pend clears on im_valid_i with no new issue.
  - A fetch PC register tracks the address of the outstanding request.
- Response handling:
  - im_valid_i && !f_stall_i: f_ir_o<=im_data_i, f_pc_o<=fetch PC, f_valid_o<=1.
  - im_valid_i && f_stall_i: capture into the one-entry skid buffer (data+pc); outputs unchanged.
  - Stall released with skid full: outputs <= skid, skid empties, no issue that cycle; issue resumes next cycle.
  - No response and !f_stall_i: f_valid_o<=0.
- Throughput: 1 instruction/cycle with 1-cycle memory; latency from im_rd_o to f_valid_o is 2 cycles (response cycle + output register).
- Redirect (x_bra_i=1, with f_kill_i), priority over stall and response:
  - pc <= x_bra_target_i; f_valid_o <= 0; skid cleared; no issue that cycle.
  - If pend && !im_valid_i, enter ST_DROP; otherwise pend <= 0.
  - The target fetch issues the cycle after the redirect, or the cycle after the dropped response arrives.
  - Redirect during ST_DROP updates pc and stays in ST_DROP.
- f_kill_i without x_bra_i: f_valid_o<=0, skid cleared; pc unchanged.
- Simultaneous stall + redirect: redirect wins.
- Misaligned target: bits [1:0] forced to 0.

Decomposition:
- rv_defs: add the fetch state encodings (FETCH_ST_RESET, FETCH_ST_RUN, FETCH_ST_DROP) and the NOP encoding constant.
- Sub-module: rv_fetch_skid (one-entry data+pc buffer with load, unload and clear).
- All PC/FSM logic stays in rv_fetch.

Test Plan:
- Reset release with g_RESET_VECTOR=0x100, 1-cycle memory returning addr as data -> im_rd_o addresses 0x100,0x104,0x108 on consecutive cycles; f_valid_o high from the 3rd cycle with f_pc_o=0x100, f_ir_o=0x100.
- f_stall_i held 3 cycles while a response (pc 0x104) arrives -> outputs frozen at pc 0x100; 0x104 is presented the first unstalled cycle; no instruction lost or duplicated.
- x_bra_i with target 0x2000 and no pending request -> f_valid_o=0 next cycle; im_addr_o=0x2000 the cycle after; f_pc_o=0x2000 two cycles later.
- x_bra_i while a 3-cycle-latency read of 0x108 is outstanding -> ST_DROP; the 0x108 response is never presented; the first valid output is pc 0x2000.
- Stall and redirect in the same cycle with skid full -> skid cleared; redirect honoured; the stale entry is never emitted.
- pc=0xFFFFFFFC sequential fetch -> next im_addr_o=0x00000000; rst_n_i=0 mid-stream -> f_valid_o=0 and the next fetch is at g_RESET_VECTOR.
